// File: rtl/carry_timer_pkg.sv
// Shared types and constants for the carry-chain down-counting timer.
package carry_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/dec_carry_slice.sv
// One bit of the decrement carry chain: XORCY-style sum and MUXCY-style borrow.
module dec_carry_slice (
  input  logic q_i,
  input  logic borrow_i,
  output logic d_o,
  output logic borrow_o
);

  assign d_o      = q_i ^ borrow_i;
  assign borrow_o = ~q_i & borrow_i;

endmodule

// File: rtl/carry_down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// Zero detect is the borrow leaving the top of the decrement chain.
module carry_down_timer
  import carry_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             STOP,
  input  logic             AUTO,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY
);

  timer_state_t     state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             tc_q;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH:0]   borrow_s;
  logic             zero_s;

  assign borrow_s[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    dec_carry_slice u_slice (
      .q_i      (q_q[i]),
      .borrow_i (borrow_s[i]),
      .d_o      (dec_s[i]),
      .borrow_o (borrow_s[i+1])
    );
  end

  assign zero_s = borrow_s[WIDTH];

  // A load on the same edge as a (re)start or reload is used immediately.
  always_comb begin
    r_d = r_q;
    if (LD) begin
      r_d = D;
    end else begin
      r_d = r_q;
    end
  end

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      q_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      tc_q    <= 1'b0;
    end else begin
      r_q  <= r_d;
      tc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START && !STOP) begin
            q_q     <= r_d;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (STOP) begin
            state_q <= IDLE;
          end else if (START) begin
            q_q <= r_d;
          end else if (CE) begin
            // Terminal branch always overrides the decrement, so Q never wraps.
            if (zero_s) begin
              tc_q <= 1'b1;
              if (AUTO) begin
                q_q <= r_d;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              q_q <= dec_s;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign TC   = tc_q;
  assign BUSY = (state_q == RUN);

endmodule

// File: tb/tb_carry_down_timer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and random stimulus against a behavioural model of the timer.
module tb_carry_down_timer;

  localparam int W = 16;

  logic         clk;
  logic         clr_n;
  logic         ce, ld, start, stop, auto_m;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         tc, busy;

  int errors = 0;
  int checks = 0;

  // behavioural model
  int unsigned m_r, m_cnt;
  bit          m_run, m_tc;

  typedef struct {
    bit         ld;
    bit [15:0]  d;
    bit         start;
    bit         stop;
    bit         auto_m;
    bit         ce;
    bit [15:0]  exp_q;
    bit         exp_tc;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[23];

  carry_down_timer #(.WIDTH(W)) dut (
    .C(clk), .CLR(clr_n), .CE(ce), .LD(ld), .D(d), .START(start),
    .STOP(stop), .AUTO(auto_m), .Q(q), .TC(tc), .BUSY(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_r = 0; m_cnt = 0; m_run = 0; m_tc = 0;
  endtask

  // Drive one edge's inputs, clock it, and advance the model by the same rules.
  task automatic tick(input bit i_ld, input int unsigned i_d, input bit i_start,
                      input bit i_stop, input bit i_auto, input bit i_ce);
    int unsigned r_eff;
    ld = i_ld; d = i_d[W-1:0]; start = i_start; stop = i_stop; auto_m = i_auto; ce = i_ce;
    @(posedge clk);
    #1;
    r_eff = i_ld ? i_d : m_r;
    m_tc  = 0;
    if (!m_run) begin
      if (i_start && !i_stop) begin m_cnt = r_eff; m_run = 1; end
    end else if (i_stop) begin
      m_run = 0;
    end else if (i_start) begin
      m_cnt = r_eff;
    end else if (i_ce) begin
      if (m_cnt == 0) begin
        m_tc = 1;
        if (i_auto) m_cnt = r_eff;
        else        m_run = 0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    m_r = r_eff;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".Q"},    q,    m_cnt);
    check({tag, ".TC"},   tc,   m_tc);
    check({tag, ".BUSY"}, busy, m_run);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    #3;
    model_reset();
    clr_n = 1'b1;
    #1;
  endtask

  initial begin
    int n, pulses;
    ld = 0; d = '0; start = 0; stop = 0; auto_m = 0; ce = 0; clr_n = 1'b0;
    model_reset();
    #12;
    check("reset.Q", q, 0);
    check("reset.TC", tc, 0);
    check("reset.BUSY", busy, 0);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;

    //                 ld  d       st sp au ce   q       tc busy
    vecs[0]  = '{1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 16'd5, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd5, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd7, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7, 1'b0, 1'b0};

    for (int i = 0; i < 23; i++) begin
      tick(vecs[i].ld, vecs[i].d, vecs[i].start, vecs[i].stop, vecs[i].auto_m, vecs[i].ce);
      check($sformatf("vec%0d.Q", i),    q,    vecs[i].exp_q);
      check($sformatf("vec%0d.TC", i),   tc,   vecs[i].exp_tc);
      check($sformatf("vec%0d.BUSY", i), busy, vecs[i].exp_busy);
    end

    // Asynchronous clear mid-count, then no restart without START.
    tick(1, 16'h0123, 1, 0, 0, 0);
    check("prereset.Q", q, 16'h0123);
    #2;
    clr_n = 1'b0;
    #1;
    check("async.Q", q, 0);
    check("async.TC", tc, 0);
    check("async.BUSY", busy, 0);
    #2;
    clr_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 1, 1);
      check_model("postclr");
    end
    check("postclr.idle", busy, 0);

    // Auto reload R=2: four pulses in twelve enabled edges.
    tick(1, 2, 1, 0, 1, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0, 1, 1);
      check_model("auto2");
      pulses += int'(tc);
    end
    check("auto2.pulses", pulses, 4);

    // R=0 auto: terminal on every enabled edge.
    tick(1, 0, 1, 0, 1, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 1, 1);
      pulses += int'(tc);
    end
    check("auto0.pulses", pulses, 5);
    tick(0, 0, 0, 1, 1, 0);

    // CE gating with R=4: fifth enabled edge lands on clock 9.
    tick(1, 4, 1, 0, 0, 0);
    n = 0;
    while (!tc && n < 40) begin
      n++;
      tick(0, 0, 0, 0, 0, n[0]);
      check_model("cegate");
    end
    check("cegate.clocks", n, 9);

    // Width boundary: full borrow ripples.
    tick(1, 16'h8000, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    check("ripple.Q", q, 16'h7FFF);
    tick(0, 0, 0, 1, 0, 0);
    tick(1, 16'hFFFF, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    check("max.first", q, 16'hFFFE);
    n = 1;
    while (!tc && n < 70000) begin
      n++;
      tick(0, 0, 0, 0, 0, 1);
    end
    check("max.period", n, 65536);
    check("max.busy", busy, 0);
    check("max.Q", q, 0);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      tick(($urandom % 4) == 0, $urandom_range(0, 6), ($urandom % 8) == 0,
           ($urandom % 16) == 0, $urandom % 2, ($urandom % 4) != 0);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
